dpb_sync_sim: RTL and testbench
===============================

Name: dpb_sync_sim

Overview:
- Single-clock true-dual-port block-RAM simulation model; next generation of the team's dual-port BSRAM model.
- Adds parametrised width and depth, both read modes (bypass/pipeline), all three write modes, defined same-cycle collision behaviour, and output-only reset.
- Memory is not cleared by reset.
- Used in RTL simulation wherever both RAM ports run on one clock domain.

Parameters:
DATA_WIDTH, 16, word width; legal 1,2,4,8,16; anything else -> $fatal at time 0
READ_MODE0, 1'b0, port A: 0 = bypass (1-cycle latency), 1 = pipeline (2-cycle latency)
READ_MODE1, 1'b0, port B read mode, same encoding
WRITE_MODE0, 2'b00, port A: 00 normal, 01 write-through, 10 read-before-write; 11 -> $fatal
WRITE_MODE1, 2'b00, port B write mode, same encoding
BLK_SEL_0, 3'b000, port A block-select match value
BLK_SEL_1, 3'b000, port B block-select match value
Derived: ABITS = $clog2(DATA_WIDTH); DEPTH = 16384 / DATA_WIDTH

Ports:
CLKA  in  1  sole clock for both ports
RESETB  in  1  reset, synchronous, active-high; clock CLKA
CEA  in  1  port A clock enable
OCEA  in  1  port A output-register enable (pipeline mode only)
WREA  in  1  port A write enable (1 write, 0 read)
ADA  in  14  port A bit address; word index = ADA[13:ABITS]
DIA  in  DATA_WIDTH  port A write data
BLKSELA  in  3  port A block select
DOA  out  DATA_WIDTH  port A read data
CEB, OCEB, WREB, ADB, DIB, BLKSELB, DOB: port B equivalents, same widths

Behaviour:
- Port X is active when BLKSELX == BLK_SEL_n and CEX == 1.
- Inactive port: no memory access; its data latch holds.
- Memory initialised to all-zero at time 0. RESETB never touches memory contents.
- RESETB = 1 at a CLKA edge: data latch, pipeline register and DOx all go to 0. Reset has priority over CE/OCE; writes in the same cycle are still performed.
- Read (active, WRE = 0): data latch <= mem[word] at the edge.
  - Bypass mode: DOx = data latch, so data appears 1 cycle after the address.
  - Pipeline mode: DOx register <= data latch when OCEx = 1, else holds; 2-cycle latency.
- Write (active, WRE = 1): mem[word] <= DI (subject to byte enables). Data latch update per write mode:
  - normal: latch holds.
  - write-through: latch <= the newly written word.
  - read-before-write: latch <= old mem[word].
- Cross-port collisions, same word in the same cycle:
  - Read on one port, write on the other: the read returns the old word.
  - Both ports write: port B value wins. If byte enables are active, the merge is per byte and B wins per byte.
  - Both ports read: both return the same value.
- Address bits below ABITS are ignored, except as described under Optional Feature.

Optional Feature:
- Macro DPB_SYNC_BYTE_WE_EN.
- Defined, with DATA_WIDTH == 16: ADx[1:0] are active-high byte write enables; bit 0 -> [7:0], bit 1 -> [15:8]; 2'b00 writes nothing. Write-through returns the merged word.
- Defined, with DATA_WIDTH != 16: the macro has no effect.
- Not defined: every write is a full-word write; ADx[1:0] are ignored in 16-bit mode.

Decomposition:
- Package dpb_sync_pkg holds:
  - typedef enum logic[1:0] write_mode_e {WM_NORMAL, WM_WRITE_THROUGH, WM_READ_BEFORE_WRITE}
  - typedef enum logic read_mode_e {RM_BYPASS, RM_PIPELINE}
  - function addr_lsb(width), returning ABITS
  - localparam TOTAL_BITS = 16384
- Sub-module dpb_sync_out_stage: per-port data latch, pipeline register, reset and OCE logic. Instantiated twice.
- The memory array and collision resolution stay in the top module.

Test Plan:
- DATA_WIDTH 16, both ports bypass: write 16'hA5A5 to word 5 via A; read word 5 via B the next cycle -> DOB = 16'hA5A5 one cycle after the read.
- Port A pipeline: read word 5 with OCEA = 1 -> DOA valid 2 cycles later. Hold OCEA = 0 -> DOA keeps its previous value.
- WRITE_MODE0 = 01 / 10: with mem[3] = 16'h1111, write 16'h2222 via A -> DOA = 16'h2222 (write-through) / 16'h1111 (read-before-write). In both cases mem[3] = 16'h2222.
- Same cycle, word 7: A writes 16'h0001 while B writes 16'h0002 -> mem[7] = 16'h0002. A writes 16'h00FF while B reads -> DOB = old value.
- Assert RESETB mid-stream after mem[2] = 16'hBEEF: DOA and DOB = 0 the next cycle. Deassert and read word 2 -> 16'hBEEF. BLKSELA mismatch during a write -> mem unchanged.
- With DPB_SYNC_BYTE_WE_EN: mem[4] = 16'h1234; write 16'hABCD with ADA[1:0] = 2'b10 -> mem[4] = 16'hAB34.

Source files
------------

// File: rtl/dpb_sync_pkg.sv
// Shared types and constants for the single-clock dual-port block-RAM model.
package dpb_sync_pkg;

    // Total storage in bits, independent of the configured word width.
    localparam int TOTAL_BITS = 16384;

    typedef enum logic [1:0] {
        WM_NORMAL            = 2'b00,
        WM_WRITE_THROUGH     = 2'b01,
        WM_READ_BEFORE_WRITE = 2'b10
    } write_mode_e;

    typedef enum logic {
        RM_BYPASS   = 1'b0,
        RM_PIPELINE = 1'b1
    } read_mode_e;

    // Number of low bit-address bits that select a bit inside a word.
    function automatic int addr_lsb(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/dpb_sync_out_stage.sv
// Per-port output path: data latch, optional output register and reset.
module dpb_sync_out_stage
    import dpb_sync_pkg::*;
#(
    parameter int   DATA_WIDTH = 16,
    parameter logic READ_MODE  = 1'b0
) (
    input  logic                  CLKA,
    input  logic                  RESETB,
    input  logic                  ld,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  oce,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] data_p0;

    // Data latch: reset wins over any load request
    always_ff @(posedge CLKA) begin
        if (RESETB)
            data_p0 <= '0;
        else if (ld)
            data_p0 <= din;
    end

    generate
        if (read_mode_e'(READ_MODE) == RM_PIPELINE) begin : g_pipe
            logic [DATA_WIDTH-1:0] data_p1;

            // Output register: advances only while OCE is high
            always_ff @(posedge CLKA) begin
                if (RESETB)
                    data_p1 <= '0;
                else if (oce)
                    data_p1 <= data_p0;
            end

            assign dout = data_p1;
        end else begin : g_bypass
            logic unused_oce;
            assign unused_oce = oce;
            assign dout       = data_p0;
        end
    endgenerate

endmodule

// File: rtl/dpb_sync_sim.sv
// Single-clock true-dual-port block-RAM simulation model.
// Optional macro DPB_SYNC_BYTE_WE_EN: in 16-bit mode, ADx[1:0] act as byte
// write enables (bit 0 -> [7:0], bit 1 -> [15:8]).
module dpb_sync_sim
    import dpb_sync_pkg::*;
#(
    parameter int         DATA_WIDTH  = 16,
    parameter logic       READ_MODE0  = 1'b0,
    parameter logic       READ_MODE1  = 1'b0,
    parameter logic [1:0] WRITE_MODE0 = 2'b00,
    parameter logic [1:0] WRITE_MODE1 = 2'b00,
    parameter logic [2:0] BLK_SEL_0   = 3'b000,
    parameter logic [2:0] BLK_SEL_1   = 3'b000
) (
    input  logic                  CLKA,
    input  logic                  RESETB,
    input  logic                  CEA,
    input  logic                  OCEA,
    input  logic                  WREA,
    input  logic [13:0]           ADA,
    input  logic [DATA_WIDTH-1:0] DIA,
    input  logic [2:0]            BLKSELA,
    output logic [DATA_WIDTH-1:0] DOA,
    input  logic                  CEB,
    input  logic                  OCEB,
    input  logic                  WREB,
    input  logic [13:0]           ADB,
    input  logic [DATA_WIDTH-1:0] DIB,
    input  logic [2:0]            BLKSELB,
    output logic [DATA_WIDTH-1:0] DOB
);

    localparam int ABITS = addr_lsb(DATA_WIDTH);
    localparam int AW    = 14 - ABITS;
    localparam int DEPTH = TOTAL_BITS / DATA_WIDTH;
    localparam write_mode_e WM_A = write_mode_e'(WRITE_MODE0);
    localparam write_mode_e WM_B = write_mode_e'(WRITE_MODE1);

    generate
        if (!(DATA_WIDTH == 1 || DATA_WIDTH == 2 || DATA_WIDTH == 4 ||
              DATA_WIDTH == 8 || DATA_WIDTH == 16)) begin : g_bad_width
            $fatal(1, "dpb_sync_sim: illegal DATA_WIDTH %0d", DATA_WIDTH);
        end
        if (WRITE_MODE0 == 2'b11) begin : g_bad_wm0
            $fatal(1, "dpb_sync_sim: illegal WRITE_MODE0");
        end
        if (WRITE_MODE1 == 2'b11) begin : g_bad_wm1
            $fatal(1, "dpb_sync_sim: illegal WRITE_MODE1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [AW-1:0]         wa, wb;
    logic                  act_a, act_b, wr_a, wr_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, mask_a, mask_b, new_a, new_b, base_b;
    logic [DATA_WIDTH-1:0] din_a, din_b;
    logic                  ld_a, ld_b;
    logic                  unused_bits;

`ifdef DPB_SYNC_BYTE_WE_EN
    function automatic logic [DATA_WIDTH-1:0] be_mask(input logic [1:0] be);
        logic [15:0] m16;
        m16 = {{8{be[1]}}, {8{be[0]}}};
        if (DATA_WIDTH == 16)
            return m16[DATA_WIDTH-1:0];
        return '1;
    endfunction
    assign mask_a = be_mask(ADA[1:0]);
    assign mask_b = be_mask(ADB[1:0]);
`else
    assign mask_a = '1;
    assign mask_b = '1;
`endif

    assign unused_bits = ^{ADA, ADB};

    // Port decode, byte merge and collision resolution (B wins per byte)
    always_comb begin
        wa     = ADA[13:ABITS];
        wb     = ADB[13:ABITS];
        act_a  = CEA && (BLKSELA == BLK_SEL_0);
        act_b  = CEB && (BLKSELB == BLK_SEL_1);
        wr_a   = act_a && WREA;
        wr_b   = act_b && WREB;
        old_a  = mem[wa];
        old_b  = mem[wb];
        new_a  = (old_a & ~mask_a) | (DIA & mask_a);
        base_b = (wr_a && (wa == wb)) ? new_a : old_b;
        new_b  = (base_b & ~mask_b) | (DIB & mask_b);
        ld_a   = act_a && !(WREA && (WM_A == WM_NORMAL));
        ld_b   = act_b && !(WREB && (WM_B == WM_NORMAL));
        din_a  = (WREA && (WM_A == WM_WRITE_THROUGH)) ? new_a : old_a;
        din_b  = (WREB && (WM_B == WM_WRITE_THROUGH)) ? new_b : old_b;
    end

    // Memory array: port B's update is issued last so it wins on collision
    always_ff @(posedge CLKA) begin
        if (wr_a)
            mem[wa] <= new_a;
        if (wr_b)
            mem[wb] <= new_b;
    end

    dpb_sync_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .READ_MODE  (READ_MODE0)
    ) u_out_a (
        .CLKA   (CLKA),
        .RESETB (RESETB),
        .ld     (ld_a),
        .din    (din_a),
        .oce    (OCEA),
        .dout   (DOA)
    );

    dpb_sync_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .READ_MODE  (READ_MODE1)
    ) u_out_b (
        .CLKA   (CLKA),
        .RESETB (RESETB),
        .ld     (ld_b),
        .din    (din_b),
        .oce    (OCEB),
        .dout   (DOB)
    );

endmodule

// File: tb/tb_dpb_sync_sim.sv
// Self-checking bench for dpb_sync_sim: four configurations share one stimulus bus.
module tb_dpb_sync_sim;

    logic        CLKA = 1'b0;
    logic        RESETB;
    logic        cea, ocea, wrea, ceb, oceb, wreb;
    logic [13:0] ada, adb;
    logic [15:0] dia, dib;
    logic [2:0]  blksela, blkselb;
    logic [15:0] doa0, dob0, doa1, dob1, doa2, dob2, doa3, dob3;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] sb [$];

    always #5 CLKA = ~CLKA;

    // u0: both bypass/normal, u1: A pipeline, u2: A write-through, u3: A read-before-write
    dpb_sync_sim #(.DATA_WIDTH(16)) u0 (
        .CLKA(CLKA), .RESETB(RESETB),
        .CEA(cea), .OCEA(ocea), .WREA(wrea), .ADA(ada), .DIA(dia), .BLKSELA(blksela), .DOA(doa0),
        .CEB(ceb), .OCEB(oceb), .WREB(wreb), .ADB(adb), .DIB(dib), .BLKSELB(blkselb), .DOB(dob0));
    dpb_sync_sim #(.DATA_WIDTH(16), .READ_MODE0(1'b1)) u1 (
        .CLKA(CLKA), .RESETB(RESETB),
        .CEA(cea), .OCEA(ocea), .WREA(wrea), .ADA(ada), .DIA(dia), .BLKSELA(blksela), .DOA(doa1),
        .CEB(ceb), .OCEB(oceb), .WREB(wreb), .ADB(adb), .DIB(dib), .BLKSELB(blkselb), .DOB(dob1));
    dpb_sync_sim #(.DATA_WIDTH(16), .WRITE_MODE0(2'b01)) u2 (
        .CLKA(CLKA), .RESETB(RESETB),
        .CEA(cea), .OCEA(ocea), .WREA(wrea), .ADA(ada), .DIA(dia), .BLKSELA(blksela), .DOA(doa2),
        .CEB(ceb), .OCEB(oceb), .WREB(wreb), .ADB(adb), .DIB(dib), .BLKSELB(blkselb), .DOB(dob2));
    dpb_sync_sim #(.DATA_WIDTH(16), .WRITE_MODE0(2'b10)) u3 (
        .CLKA(CLKA), .RESETB(RESETB),
        .CEA(cea), .OCEA(ocea), .WREA(wrea), .ADA(ada), .DIA(dia), .BLKSELA(blksela), .DOA(doa3),
        .CEB(ceb), .OCEB(oceb), .WREB(wreb), .ADB(adb), .DIB(dib), .BLKSELB(blkselb), .DOB(dob3));

    task automatic tick();
        @(posedge CLKA);
        #1;
    endtask

    task automatic drive_a(input logic ce, input logic we, input int word,
                           input logic [15:0] d, input logic [1:0] lsb = 2'b11);
        cea  = ce;
        wrea = we;
        ada  = {word[9:0], 2'b00, lsb};
        dia  = d;
    endtask

    task automatic drive_b(input logic ce, input logic we, input int word,
                           input logic [15:0] d, input logic [1:0] lsb = 2'b11);
        ceb  = ce;
        wreb = we;
        adb  = {word[9:0], 2'b00, lsb};
        dib  = d;
    endtask

    task automatic idle();
        drive_a(1'b0, 1'b0, 0, 16'h0);
        drive_b(1'b0, 1'b0, 0, 16'h0);
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        RESETB = 1'b1;
        idle();
        tick();
        tick();
        sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h0);
        exp = sb.pop_front(); n_cmp++;
        if (doa0 !== exp) begin n_fail++; $display("FAIL reset_doa0 got %h want %h", doa0, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (dob0 !== exp) begin n_fail++; $display("FAIL reset_dob0 got %h want %h", dob0, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (doa1 !== exp) begin n_fail++; $display("FAIL reset_doa1 got %h want %h", doa1, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (doa2 !== exp) begin n_fail++; $display("FAIL reset_doa2 got %h want %h", doa2, exp); end
        RESETB = 1'b0;
    endtask

    task automatic test_bypass();
        logic [15:0] exp;
        drive_a(1'b1, 1'b1, 5, 16'hA5A5);
        tick();
        drive_a(1'b0, 1'b0, 0, 16'h0);
        drive_b(1'b1, 1'b0, 5, 16'h0);
        sb.push_back(16'hA5A5);
        tick();
        idle();
        exp = sb.pop_front(); n_cmp++;
        if (dob0 !== exp) begin n_fail++; $display("FAIL bypass_read got %h want %h", dob0, exp); end
    endtask

    task automatic test_pipeline();
        logic [15:0] exp;
        drive_a(1'b1, 1'b1, 6, 16'h1234);
        tick();
        drive_a(1'b1, 1'b0, 5, 16'h0);
        ocea = 1'b1;
        sb.push_back(16'h0000);
        tick();
        exp = sb.pop_front(); n_cmp++;
        if (doa1 !== exp) begin n_fail++; $display("FAIL pipe_not_yet got %h want %h", doa1, exp); end
        drive_a(1'b0, 1'b0, 0, 16'h0);
        sb.push_back(16'hA5A5);
        tick();
        exp = sb.pop_front(); n_cmp++;
        if (doa1 !== exp) begin n_fail++; $display("FAIL pipe_latency2 got %h want %h", doa1, exp); end
        drive_a(1'b1, 1'b0, 6, 16'h0);
        ocea = 1'b0;
        tick();
        drive_a(1'b0, 1'b0, 0, 16'h0);
        sb.push_back(16'hA5A5);
        tick();
        exp = sb.pop_front(); n_cmp++;
        if (doa1 !== exp) begin n_fail++; $display("FAIL pipe_oce_hold got %h want %h", doa1, exp); end
        ocea = 1'b1;
        sb.push_back(16'h1234);
        tick();
        exp = sb.pop_front(); n_cmp++;
        if (doa1 !== exp) begin n_fail++; $display("FAIL pipe_oce_release got %h want %h", doa1, exp); end
        ocea = 1'b0;
    endtask

    task automatic test_write_modes();
        logic [15:0] exp;
        drive_a(1'b1, 1'b0, 5, 16'h0);
        tick();
        drive_a(1'b1, 1'b1, 3, 16'h1111);
        sb.push_back(16'h0000); sb.push_back(16'h1111);
        tick();
        exp = sb.pop_front(); n_cmp++;
        if (doa3 !== exp) begin n_fail++; $display("FAIL rbw_init_zero got %h want %h", doa3, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (doa2 !== exp) begin n_fail++; $display("FAIL wt_first got %h want %h", doa2, exp); end
        drive_a(1'b1, 1'b1, 3, 16'h2222);
        sb.push_back(16'h2222); sb.push_back(16'h1111); sb.push_back(16'hA5A5);
        tick();
        exp = sb.pop_front(); n_cmp++;
        if (doa2 !== exp) begin n_fail++; $display("FAIL write_through got %h want %h", doa2, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (doa3 !== exp) begin n_fail++; $display("FAIL read_before_write got %h want %h", doa3, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (doa0 !== exp) begin n_fail++; $display("FAIL normal_hold got %h want %h", doa0, exp); end
        drive_a(1'b0, 1'b0, 0, 16'h0);
        drive_b(1'b1, 1'b0, 3, 16'h0);
        sb.push_back(16'h2222); sb.push_back(16'h2222);
        tick();
        idle();
        exp = sb.pop_front(); n_cmp++;
        if (dob2 !== exp) begin n_fail++; $display("FAIL wt_mem got %h want %h", dob2, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (dob3 !== exp) begin n_fail++; $display("FAIL rbw_mem got %h want %h", dob3, exp); end
    endtask

    task automatic test_collision();
        logic [15:0] exp;
        drive_a(1'b1, 1'b1, 7, 16'h0001);
        drive_b(1'b1, 1'b1, 7, 16'h0002);
        tick();
        idle();
        drive_a(1'b1, 1'b0, 7, 16'h0);
        sb.push_back(16'h0002);
        tick();
        exp = sb.pop_front(); n_cmp++;
        if (doa0 !== exp) begin n_fail++; $display("FAIL ww_b_wins got %h want %h", doa0, exp); end
        drive_a(1'b1, 1'b1, 7, 16'h00FF);
        drive_b(1'b1, 1'b0, 7, 16'h0);
        sb.push_back(16'h0002);
        tick();
        exp = sb.pop_front(); n_cmp++;
        if (dob0 !== exp) begin n_fail++; $display("FAIL rw_old_word got %h want %h", dob0, exp); end
        drive_a(1'b1, 1'b0, 7, 16'h0);
        drive_b(1'b1, 1'b0, 7, 16'h0);
        sb.push_back(16'h00FF); sb.push_back(16'h00FF);
        tick();
        idle();
        exp = sb.pop_front(); n_cmp++;
        if (doa0 !== exp) begin n_fail++; $display("FAIL rr_a got %h want %h", doa0, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (dob0 !== exp) begin n_fail++; $display("FAIL rr_b got %h want %h", dob0, exp); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        drive_a(1'b1, 1'b1, 2, 16'hBEEF);
        tick();
        drive_a(1'b1, 1'b0, 2, 16'h0);
        drive_b(1'b1, 1'b0, 2, 16'h0);
        ocea = 1'b1;
        sb.push_back(16'hBEEF);
        tick();
        exp = sb.pop_front(); n_cmp++;
        if (doa0 !== exp) begin n_fail++; $display("FAIL pre_reset got %h want %h", doa0, exp); end
        RESETB = 1'b1;
        drive_a(1'b1, 1'b1, 8, 16'h5555);
        sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h0);
        tick();
        RESETB = 1'b0;
        ocea   = 1'b0;
        exp = sb.pop_front(); n_cmp++;
        if (doa0 !== exp) begin n_fail++; $display("FAIL mid_reset_doa got %h want %h", doa0, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (dob0 !== exp) begin n_fail++; $display("FAIL mid_reset_dob got %h want %h", dob0, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (doa1 !== exp) begin n_fail++; $display("FAIL mid_reset_pipe got %h want %h", doa1, exp); end
        drive_a(1'b1, 1'b0, 2, 16'h0);
        drive_b(1'b1, 1'b0, 8, 16'h0);
        sb.push_back(16'hBEEF); sb.push_back(16'h5555);
        tick();
        exp = sb.pop_front(); n_cmp++;
        if (doa0 !== exp) begin n_fail++; $display("FAIL mem_kept got %h want %h", doa0, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (dob0 !== exp) begin n_fail++; $display("FAIL write_in_reset got %h want %h", dob0, exp); end
        blksela = 3'b001;
        drive_a(1'b1, 1'b1, 2, 16'h0000);
        drive_b(1'b0, 1'b0, 0, 16'h0);
        sb.push_back(16'hBEEF);
        tick();
        blksela = 3'b000;
        exp = sb.pop_front(); n_cmp++;
        if (doa2 !== exp) begin n_fail++; $display("FAIL blksel_latch_hold got %h want %h", doa2, exp); end
        drive_a(1'b1, 1'b0, 2, 16'h0);
        sb.push_back(16'hBEEF);
        tick();
        idle();
        exp = sb.pop_front(); n_cmp++;
        if (doa0 !== exp) begin n_fail++; $display("FAIL blksel_no_write got %h want %h", doa0, exp); end
    endtask

    task automatic test_byte_en();
        logic [15:0] exp;
        drive_a(1'b1, 1'b1, 4, 16'h1234);
        tick();
        drive_a(1'b1, 1'b1, 4, 16'hABCD, 2'b10);
        tick();
        drive_a(1'b0, 1'b0, 0, 16'h0);
        drive_b(1'b1, 1'b0, 4, 16'h0);
`ifdef DPB_SYNC_BYTE_WE_EN
        sb.push_back(16'hAB34);
`else
        sb.push_back(16'hABCD);
`endif
        tick();
        idle();
        exp = sb.pop_front(); n_cmp++;
        if (dob0 !== exp) begin n_fail++; $display("FAIL byte_enable got %h want %h", dob0, exp); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETB  = 1'b1;
        ocea    = 1'b0;
        oceb    = 1'b0;
        blksela = 3'b000;
        blkselb = 3'b000;
        idle();
        test_reset();
        test_bypass();
        test_pipeline();
        test_write_modes();
        test_collision();
        test_reset_mid();
        test_byte_en();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
